// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: ALU opcode and funct encodings, ALU control,
// execute-stage FSM states and the control bundle carried into EX/MEM.
package cpu_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_MULT = 6'b011000;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_SLT  = 3'd4,
        ALU_ZERO = 3'd5
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } ex_state_t;

    typedef struct packed {
        logic branch;
        logic reg_write;
        logic mem_to_reg;
        logic mem_write;
        logic mem_read;
        logic reg_dst;
    } ex_ctrl_t;

endpackage

// File: rtl/alu_ctrl_alu.sv
// Combinational ALU control decode plus single-cycle ALU. Multiply is handled
// by the iterative unit in ex_stage, so its funct decodes to a zero result here.
module alu_ctrl_alu
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    alu_ctrl_t ctrl_s;
    logic      slt_s;

    assign slt_s = ($signed(a) < $signed(b));

    // Map the ID/EX alu_op and funct field to an internal ALU operation.
    always_comb begin
        ctrl_s = ALU_ZERO;
        case (alu_op)
            ALUOP_ADD: ctrl_s = ALU_ADD;
            ALUOP_SUB: ctrl_s = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: ctrl_s = ALU_ADD;
                    FUNCT_SUB: ctrl_s = ALU_SUB;
                    FUNCT_AND: ctrl_s = ALU_AND;
                    FUNCT_OR:  ctrl_s = ALU_OR;
                    FUNCT_SLT: ctrl_s = ALU_SLT;
                    default:   ctrl_s = ALU_ZERO;
                endcase
            end
            default: ctrl_s = ALU_ZERO;
        endcase
    end

    // Datapath for the selected operation; add/sub wrap silently.
    always_comb begin
        result = {WIDTH{1'b0}};
        case (ctrl_s)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, slt_s};
            ALU_ZERO: result = {WIDTH{1'b0}};
            default:  result = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU path, iterative shift-add multiplier that
// stalls upstream via ex_busy, and the falling-edge EX/MEM pipeline register.
module ex_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             branch,
    input  logic             reg_write,
    input  logic             mem_to_reg,
    input  logic             mem_write,
    input  logic             mem_read,
    input  logic             alu_src,
    input  logic             reg_dst,
    input  logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] nextpc,
    input  logic [WIDTH-1:0] reg_file_rd_data1,
    input  logic [WIDTH-1:0] reg_file_rd_data2,
    input  logic [WIDTH-1:0] sgn_ext_imm,
    input  logic [4:0]       rd_in,
    output logic             ex_busy,
    output logic [WIDTH-1:0] alu_result_out,
    output logic [WIDTH-1:0] branch_target_out,
    output logic [WIDTH-1:0] write_data_out,
    output logic             zero_out,
    output logic [4:0]       rd_out,
    output logic             branch_out,
    output logic             reg_write_out,
    output logic             mem_to_reg_out,
    output logic             mem_write_out,
    output logic             mem_read_out,
    output logic             reg_dst_out
);

    localparam int               CNT_W    = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ex_state_t        state_r, state_nxt_s;
    ex_ctrl_t         ctrl_in_s, cap_ctrl_r, ctrl_nxt_s;
    logic [5:0]       funct_s;
    logic [WIDTH-1:0] op_b_s, alu_res_s, branch_target_s;
    logic             is_mult_s;
    logic [WIDTH-1:0] mcand_r, mplier_r, acc_r, cap_wd_r, cap_bt_r;
    logic [CNT_W-1:0] cnt_r;
    logic [4:0]       cap_rd_r, rd_nxt_s;
    logic [WIDTH-1:0] res_nxt_s, bt_nxt_s, wd_nxt_s;
    logic             zero_nxt_s;

    assign funct_s         = sgn_ext_imm[5:0];
    assign op_b_s          = alu_src ? sgn_ext_imm : reg_file_rd_data2;
    assign branch_target_s = nextpc + {sgn_ext_imm[WIDTH-3:0], 2'b00};
    assign ctrl_in_s       = {branch, reg_write, mem_to_reg, mem_write, mem_read, reg_dst};
    // A bubble has reg_write low, so it can never launch a multiply.
    assign is_mult_s       = (alu_op == ALUOP_RTYPE) && (funct_s == FUNCT_MULT) && reg_write;

    alu_ctrl_alu #(.WIDTH(WIDTH)) u_alu (
        .alu_op (alu_op),
        .funct  (funct_s),
        .a      (reg_file_rd_data1),
        .b      (op_b_s),
        .result (alu_res_s)
    );

    // FSM state register.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state; flush overrides everything and aborts a multiply.
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_nxt_s = is_mult_s ? MUL : IDLE;
                MUL:     state_nxt_s = (cnt_r == CNT_LAST) ? DONE : MUL;
                DONE:    state_nxt_s = IDLE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // FSM outputs: stall request and the value presented to EX/MEM.
    always_comb begin
        ex_busy    = ((state_r == IDLE) && is_mult_s) || (state_r == MUL);
        res_nxt_s  = {WIDTH{1'b0}};
        bt_nxt_s   = {WIDTH{1'b0}};
        wd_nxt_s   = {WIDTH{1'b0}};
        zero_nxt_s = 1'b0;
        rd_nxt_s   = 5'd0;
        ctrl_nxt_s = '0;
        if (flush) begin
            ctrl_nxt_s = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!is_mult_s) begin
                        res_nxt_s  = alu_res_s;
                        bt_nxt_s   = branch_target_s;
                        wd_nxt_s   = reg_file_rd_data2;
                        zero_nxt_s = (alu_res_s == {WIDTH{1'b0}});
                        rd_nxt_s   = rd_in;
                        ctrl_nxt_s = ctrl_in_s;
                    end else begin
                        ctrl_nxt_s = '0;
                    end
                end
                MUL: ctrl_nxt_s = '0;
                DONE: begin
                    res_nxt_s  = acc_r;
                    bt_nxt_s   = cap_bt_r;
                    wd_nxt_s   = cap_wd_r;
                    zero_nxt_s = (acc_r == {WIDTH{1'b0}});
                    rd_nxt_s   = cap_rd_r;
                    ctrl_nxt_s = cap_ctrl_r;
                end
                default: ctrl_nxt_s = '0;
            endcase
        end
    end

    // Multiplier capture and shift-add iteration.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            mcand_r    <= {WIDTH{1'b0}};
            mplier_r   <= {WIDTH{1'b0}};
            acc_r      <= {WIDTH{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            cap_wd_r   <= {WIDTH{1'b0}};
            cap_bt_r   <= {WIDTH{1'b0}};
            cap_rd_r   <= 5'd0;
            cap_ctrl_r <= '0;
        end else if (!flush && (state_r == IDLE) && is_mult_s) begin
            mcand_r    <= reg_file_rd_data1;
            mplier_r   <= op_b_s;
            acc_r      <= {WIDTH{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            cap_wd_r   <= reg_file_rd_data2;
            cap_bt_r   <= branch_target_s;
            cap_rd_r   <= rd_in;
            cap_ctrl_r <= ctrl_in_s;
        end else if (!flush && (state_r == MUL)) begin
            if (mplier_r[0]) begin
                acc_r <= acc_r + mcand_r;
            end
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CNT_ONE;
        end
    end

    // EX/MEM pipeline register.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            alu_result_out    <= {WIDTH{1'b0}};
            branch_target_out <= {WIDTH{1'b0}};
            write_data_out    <= {WIDTH{1'b0}};
            zero_out          <= 1'b0;
            rd_out            <= 5'd0;
            branch_out        <= 1'b0;
            reg_write_out     <= 1'b0;
            mem_to_reg_out    <= 1'b0;
            mem_write_out     <= 1'b0;
            mem_read_out      <= 1'b0;
            reg_dst_out       <= 1'b0;
        end else begin
            alu_result_out    <= res_nxt_s;
            branch_target_out <= bt_nxt_s;
            write_data_out    <= wd_nxt_s;
            zero_out          <= zero_nxt_s;
            rd_out            <= rd_nxt_s;
            branch_out        <= ctrl_nxt_s.branch;
            reg_write_out     <= ctrl_nxt_s.reg_write;
            mem_to_reg_out    <= ctrl_nxt_s.mem_to_reg;
            mem_write_out     <= ctrl_nxt_s.mem_write;
            mem_read_out      <= ctrl_nxt_s.mem_read;
            reg_dst_out       <= ctrl_nxt_s.reg_dst;
        end
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage pipeline. It consumes the ID/EX pipeline register outputs and computes the ALU result, zero flag and branch target, and drives the EX/MEM pipeline register. An iterative 32-cycle shift-add multiplier stalls the upstream pipeline through `ex_busy`. It sits directly downstream of `ID_EX_reg`, and its registered outputs feed the MEM stage.

## Interface
- Parameters: `WIDTH`, 32, datapath width. `MUL_CYCLES`, 32, multiplier iterations; must equal `WIDTH`.
- `clk` in 1: pipeline clock. All state updates on the falling edge, matching the other pipeline registers.
- `reset` in 1: one clock; reset is asynchronous and active-high.
- `flush` in 1: synchronous squash from the branch unit, sampled on the falling edge.
- `branch`, `reg_write`, `mem_to_reg`, `mem_write`, `mem_read`, `alu_src`, `reg_dst` in 1 each: control bits from ID/EX.
- `alu_op` in 2: 00 add, 01 sub, 10 R-type (decoded from funct = `sgn_ext_imm[5:0]`).
- `nextpc`, `reg_file_rd_data1`, `reg_file_rd_data2`, `sgn_ext_imm` in 32 each: operands from ID/EX.
- `rd_in` in 5: destination register.
- `ex_busy` out 1: combinational stall request. The hazard unit freezes the PC, IF/ID and ID/EX while it is high.
- `alu_result_out`, `branch_target_out`, `write_data_out` out 32 each: EX/MEM data.
- `zero_out` out 1: registered `alu_result == 0`.
- `rd_out` out 5: registered destination register.
- `branch_out`, `reg_write_out`, `mem_to_reg_out`, `mem_write_out`, `mem_read_out`, `reg_dst_out` out 1 each: registered control.

## Operation
- Operand B = `alu_src` ? `sgn_ext_imm` : `reg_file_rd_data2`.
- `branch_target` = `nextpc + (sgn_ext_imm << 2)`, mod 2^32.
- R-type funct codes:
  - 100000 add, 100010 sub; both wrap mod 2^32 with no overflow trap.
  - 100100 and, 100101 or.
  - 101010 slt: signed compare; result is 1 or 0, zero-extended.
  - 011000 mult: low 32 bits of the unsigned product.
  - Any other funct: result 0.
- Bubble: all control inputs 0. It passes through as a bubble and never starts a multiply.
- `is_mult` = `alu_op`==10 && funct==011000 && `reg_write`.
- FSM states: IDLE, MUL, DONE.
  - IDLE, `is_mult`: at the edge, capture multiplicand, multiplier, `rd`, `reg_dst` and control; acc=0, cnt=0; go to MUL. EX/MEM receives a bubble.
  - IDLE, not `is_mult`: single-cycle ALU result and pass-through written to EX/MEM.
  - MUL: each edge, if multiplier[0] then acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; cnt++. At cnt==MUL_CYCLES-1 (last iteration), go to DONE. EX/MEM receives a bubble each edge. ID/EX contents are ignored.
  - DONE: at the next edge, EX/MEM gets acc and the captured control/rd, with `zero_out` = (acc==0) and `write_data_out`/`branch_target_out` = captured values; go to IDLE. The frozen ID/EX mult is considered consumed.
- `ex_busy` = (IDLE && `is_mult`) || MUL. It is low in DONE.
- Priority: `reset` > `flush` > FSM.
  - `flush` at any edge: EX/MEM gets a bubble and the FSM goes to IDLE, aborting any multiply with no result written.

## Timing
- Reset values: all outputs 0, FSM in IDLE. `ex_busy` follows the inputs combinationally.
- Non-mult instruction: result visible in EX/MEM one falling edge after it appears in ID/EX.
- Multiply: capture at edge E0, iterations at E1..E32, result in EX/MEM at E33. `ex_busy` is high for 33 cycles (from ID/EX valid until E32).
- Reset asserted mid-multiply: immediate return to IDLE with all outputs 0. The partial product is discarded.
- Flush and a multiply start on the same edge: the flush wins, so no capture occurs. `ex_busy` may still be high in that cycle; the hazard unit ignores it under flush.

## Structure
- Shared package `cpu_pkg`:
  - `alu_op` encodings (ALUOP_ADD/SUB/RTYPE).
  - funct constants.
  - internal ALU control enum.
  - FSM state enum.
  - `WIDTH` default.
- One sub-module, `alu_ctrl_alu`: combinational ALU control plus ALU, excluding mult. The multiplier FSM and the EX/MEM registers live in `ex_stage`.

## Test plan
- Reset: assert `reset` mid-cycle → all outputs 0 immediately.
- Add: `alu_op`=10, funct 100000, data1=5, data2=0xFFFFFFFF → `alu_result_out`=4, `zero_out`=0 after 1 edge.
- Slt: slt with -3 vs 2 → result 1. Beq sub with 7 vs 7 → `zero_out`=1. With `nextpc`=0x100 and imm=-1, `branch_target_out`=0xFC.
- Multiply: mult 0x10000 × 0x10001 → `ex_busy` high for 33 cycles; bubbles (`reg_write_out`=0) during E0..E32; result 0x00010000 with `reg_write_out`=1 and the captured `rd` at E33; the next instruction follows on the edge after.
- Flush mid-multiply: `flush` at E10 of a multiply → bubble, FSM returns to IDLE, `ex_busy` drops, no result written.
- Bubble: all-zero control with funct=011000 → no multiply starts, `ex_busy`=0.
